// File: rtl/ldl_cdc_hand_rx_v2.sv
// Receive side of a multi-channel two-phase toggle handshake CDC.
// Request toggles are synchronised per channel, and held words are merged round-robin into one stream.

module ldl_cdc_hand_rx_v2_sync #(
  parameter int LEVEL = 2
) (
  input  logic rx_clk,
  input  logic rx_rst_n,
  input  logic d,
  output logic q
);
  logic [LEVEL-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[LEVEL-2:0], d};

  always_ff @(posedge rx_clk or negedge rx_rst_n)
    if (!rx_rst_n) sync_q <= '0;
    else           sync_q <= sync_d;

  assign q = sync_q[LEVEL-1];
endmodule

module ldl_cdc_hand_rx_v2 #(
  parameter int CH    = 4,
  parameter int DW    = 8,
  parameter int LEVEL = 2,
  parameter int CHW   = $clog2(CH)
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic [CH-1:0]    req_tgl,
  input  logic [CH*DW-1:0] din,
  output logic [CH-1:0]    ack_tgl,
  output logic [DW-1:0]    dout,
  output logic [CHW-1:0]   dout_ch,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [CH-1:0]    pend
);
  logic [CH-1:0]         req_s;
  logic [CH-1:0][DW-1:0] din_a;
  logic [CH-1:0]         ack_q, ack_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic                  vld_q, vld_d;
  logic [CHW-1:0]        ptr_q, ptr_d;
  logic [CHW:0]          sum;
  logic [CHW-1:0]        gnt_idx;
  logic                  gnt_found;
  logic                  load;

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_lane
    ldl_cdc_hand_rx_v2_sync #(.LEVEL(LEVEL)) u_sync (
      .rx_clk  (rx_clk),
      .rx_rst_n(rx_rst_n),
      .d       (req_tgl[gi]),
      .q       (req_s[gi])
    );
  end

  assign din_a = din;
  assign pend  = req_s ^ ack_q;
  assign load  = ~vld_q | dout_rdy;

  // First pending channel at or after ptr, with an explicit wrap so CH need not be a power of 2.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < CH; k++) begin
      sum = {1'b0, ptr_q} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(CH)) sum = sum - (CHW+1)'(CH);
      if (!gnt_found && pend[sum[CHW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[CHW-1:0];
      end
    end
  end

  always_comb begin
    ack_d  = ack_q;
    dout_d = dout_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load && gnt_found) begin
      dout_d         = din_a[gnt_idx];
      ch_d           = gnt_idx;
      vld_d          = 1'b1;
      ack_d[gnt_idx] = ~ack_q[gnt_idx];
      ptr_d          = (gnt_idx == CHW'(CH-1)) ? '0 : gnt_idx + CHW'(1);
    end else if (dout_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n)
    if (!rx_rst_n) begin
      ack_q  <= '0;
      dout_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      dout_q <= dout_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end

  assign ack_tgl  = ack_q;
  assign dout     = dout_q;
  assign dout_ch  = ch_q;
  assign dout_vld = vld_q;
endmodule

// File: tb/tb_ldl_cdc_hand_rx_v2.sv
// Directed vectors plus scoreboarded random senders for ldl_cdc_hand_rx_v2 (CH=4 and CH=3 instances).

module tb_ldl_cdc_hand_rx_v2;
  localparam int NW = 30;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic [3:0]  req_tgl;
  logic [31:0] din;
  logic [3:0]  ack_tgl;
  logic [7:0]  dout;
  logic [1:0]  dout_ch;
  logic        dout_vld;
  logic        dout_rdy;
  logic [3:0]  pend;

  logic [2:0]  req3;
  logic [23:0] din3;
  logic [2:0]  ack3;
  logic [7:0]  dout3;
  logic [1:0]  ch3o;
  logic        vld3;
  logic        rdy3;
  logic [2:0]  pend3;

  ldl_cdc_hand_rx_v2 #(.CH(4), .DW(8), .LEVEL(2)) u4 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .req_tgl(req_tgl), .din(din),
    .ack_tgl(ack_tgl), .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .pend(pend)
  );

  ldl_cdc_hand_rx_v2 #(.CH(3), .DW(8), .LEVEL(2)) u3 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .req_tgl(req3), .din(din3),
    .ack_tgl(ack3), .dout(dout3), .dout_ch(ch3o), .dout_vld(vld3),
    .dout_rdy(rdy3), .pend(pend3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  function automatic logic [7:0] exp_data(input int c, input int s);
    return 8'((c * 61 + s * 7 + 3) & 255);
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic        rdy;
    logic        vld;
    logic [7:0]  dout;
    logic [1:0]  ch;
    logic [3:0]  ack;
    logic [3:0]  pend;
  } vec_t;

  vec_t vt [18];
  int   sent [4];
  int   rcvd [4];

  initial begin
    // fairness from ptr=0
    vt[0]  = '{4'b1111, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000};
    vt[1]  = '{4'b1111, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000, 4'b1111};
    vt[2]  = '{4'b1111, 32'h13121110, 1'b1, 1'b1, 8'h10, 2'd0, 4'b0001, 4'b1110};
    vt[3]  = '{4'b1111, 32'h13121110, 1'b1, 1'b1, 8'h11, 2'd1, 4'b0011, 4'b1100};
    vt[4]  = '{4'b1111, 32'h13121110, 1'b1, 1'b1, 8'h12, 2'd2, 4'b0111, 4'b1000};
    vt[5]  = '{4'b1111, 32'h13121110, 1'b1, 1'b1, 8'h13, 2'd3, 4'b1111, 4'b0000};
    vt[6]  = '{4'b1111, 32'h13121110, 1'b1, 1'b0, 8'h13, 2'd3, 4'b1111, 4'b0000};
    // single transfer on ch1, visible at the third edge
    vt[7]  = '{4'b1101, 32'h1312A510, 1'b1, 1'b0, 8'h13, 2'd3, 4'b1111, 4'b0000};
    vt[8]  = '{4'b1101, 32'h1312A510, 1'b1, 1'b0, 8'h13, 2'd3, 4'b1111, 4'b0010};
    vt[9]  = '{4'b1101, 32'h1312A510, 1'b1, 1'b1, 8'hA5, 2'd1, 4'b1101, 4'b0000};
    vt[10] = '{4'b1101, 32'h1312A510, 1'b1, 1'b0, 8'hA5, 2'd1, 4'b1101, 4'b0000};
    // backpressure: ch3 and ch0 pending with ptr=2
    vt[11] = '{4'b0100, 32'h6612A555, 1'b0, 1'b0, 8'hA5, 2'd1, 4'b1101, 4'b0000};
    vt[12] = '{4'b0100, 32'h6612A555, 1'b0, 1'b0, 8'hA5, 2'd1, 4'b1101, 4'b1001};
    vt[13] = '{4'b0100, 32'h6612A555, 1'b0, 1'b1, 8'h66, 2'd3, 4'b0101, 4'b0001};
    vt[14] = '{4'b0100, 32'h6612A555, 1'b0, 1'b1, 8'h66, 2'd3, 4'b0101, 4'b0001};
    vt[15] = '{4'b0100, 32'h6612A555, 1'b0, 1'b1, 8'h66, 2'd3, 4'b0101, 4'b0001};
    vt[16] = '{4'b0100, 32'h6612A555, 1'b1, 1'b1, 8'h55, 2'd0, 4'b0100, 4'b0000};
    vt[17] = '{4'b0100, 32'h6612A555, 1'b1, 1'b0, 8'h55, 2'd0, 4'b0100, 4'b0000};

    req_tgl = '0; din = '0; dout_rdy = 1'b1;
    req3 = '0; din3 = '0; rdy3 = 1'b1;
    rx_rst_n = 1'b0;
    step(); step();
    chk("rst ack", 32'(ack_tgl), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst ch", 32'(dout_ch), 0);
    chk("rst vld", 32'(dout_vld), 0);
    chk("rst pend", 32'(pend), 0);
    chk("rst3 ack", 32'(ack3), 0);
    rx_rst_n = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      req_tgl = vt[i].req; din = vt[i].din; dout_rdy = vt[i].rdy;
      step();
      chk($sformatf("vec%0d vld", i), 32'(dout_vld), 32'(vt[i].vld));
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vt[i].dout));
      chk($sformatf("vec%0d ch", i), 32'(dout_ch), 32'(vt[i].ch));
      chk($sformatf("vec%0d ack", i), 32'(ack_tgl), 32'(vt[i].ack));
      chk($sformatf("vec%0d pend", i), 32'(pend), 32'(vt[i].pend));
    end

    // CH=3 wrap: ch1 transfer leaves ptr=2, then ch0+ch2 must come out 2 then 0
    req3 = 3'b010; din3 = {8'h22, 8'hB1, 8'h00};
    step(); step(); step();
    chk("wrap ch1 vld", 32'(vld3), 1);
    chk("wrap ch1 ch", 32'(ch3o), 1);
    chk("wrap ch1 dout", 32'(dout3), 32'hB1);
    step();
    req3 = 3'b111; din3 = {8'hC2, 8'hB1, 8'hC0};
    step(); step(); step();
    chk("wrap g0 ch", 32'(ch3o), 2);
    chk("wrap g0 dout", 32'(dout3), 32'hC2);
    step();
    chk("wrap g1 ch", 32'(ch3o), 0);
    chk("wrap g1 dout", 32'(dout3), 32'hC0);
    step();
    chk("wrap idle vld", 32'(vld3), 0);
    chk("wrap ack", 32'(ack3), 32'b111);
    // ptr must now be 1: all three pending come out 1,2,0
    req3 = 3'b000; din3 = {8'hD2, 8'hD1, 8'hD0};
    step(); step(); step();
    chk("ptr g0 ch", 32'(ch3o), 1);
    step();
    chk("ptr g1 ch", 32'(ch3o), 2);
    step();
    chk("ptr g2 ch", 32'(ch3o), 0);
    chk("ptr g2 dout", 32'(dout3), 32'hD0);
    step();

    // async reset while dout_vld=1 and ch2's toggle sits in the sync chain
    req_tgl = 4'b0110; din = 32'h6612_7755; dout_rdy = 1'b0;
    step(); step();
    req_tgl = 4'b0010;
    step();
    chk("pre-rst vld", 32'(dout_vld), 1);
    chk("pre-rst dout", 32'(dout), 32'h77);
    #2 rx_rst_n = 1'b0;
    #1;
    chk("async rst vld", 32'(dout_vld), 0);
    chk("async rst dout", 32'(dout), 0);
    chk("async rst ch", 32'(dout_ch), 0);
    chk("async rst ack", 32'(ack_tgl), 0);
    chk("async rst pend", 32'(pend), 0);
    req_tgl = '0; din = '0; dout_rdy = 1'b1; req3 = '0;
    step();
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post-rst%0d vld", i), 32'(dout_vld), 0);
      chk($sformatf("post-rst%0d pend", i), 32'(pend), 0);
    end

    // random senders obeying one-outstanding, random ready
    for (int c = 0; c < 4; c++) begin sent[c] = 0; rcvd[c] = 0; end
    begin
      int  cyc;
      bit  done;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 4000) begin
        dout_rdy = ($urandom_range(0, 3) != 0);
        if (dout_vld && dout_rdy) begin
          int c;
          c = int'(dout_ch);
          if (rcvd[c] >= sent[c]) begin
            chk($sformatf("rnd spurious ch%0d", c), 32'(rcvd[c]), 32'(sent[c]) - 1);
          end else begin
            chk($sformatf("rnd ch%0d word%0d", c, rcvd[c]), 32'(dout), 32'(exp_data(c, rcvd[c])));
          end
          rcvd[c]++;
        end
        for (int c = 0; c < 4; c++) begin
          if (req_tgl[c] == ack_tgl[c] && sent[c] < NW && $urandom_range(0, 2) == 0) begin
            din[c*8 +: 8] = exp_data(c, sent[c]);
            req_tgl[c] = ~req_tgl[c];
            sent[c]++;
          end
        end
        done = 1'b1;
        for (int c = 0; c < 4; c++)
          if (rcvd[c] < NW) done = 1'b0;
        if (!done) step();
        cyc++;
      end
      chk("rnd completed in budget", 32'(done), 1);
      for (int c = 0; c < 4; c++)
        chk($sformatf("rnd ch%0d delivered", c), 32'(rcvd[c]), NW);
      step(); step();
      chk("rnd final pend", 32'(pend), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
